// File: rtl/seven_seg_capture.sv
// seven_seg_capture
//   Recovers hex digits from a multiplexed seven-segment display bus. The
//   segment and digit-select lines are registered once, then a small FSM waits
//   for STABLE_CYCLES identical one-hot samples before decoding the pattern
//   into the selected digit.
//
// Parameters
//   NUM_DIGITS    number of multiplexed digit positions (1..8)
//   STABLE_CYCLES identical consecutive samples required for a capture (1..255)
//
// Ports
//   clk          clock, all state on the rising edge
//   reset        asynchronous active-high reset
//   seg_in       segments, bit0=a .. bit6=g
//   dig_sel      digit enables, one-hot while a digit is driven
//   clear        synchronous clear of the captured digits and err
//   hex_out      decoded nibble per digit, digit i at [4i+3:4i]
//   digit_valid  digit i currently holds a decoded hex value
//   update       one-cycle pulse on every capture
//   err          sticky, set when an unrecognised pattern is captured
//
// Build option
//   SEG_ACTIVE_LOW_EN  define for common-anode displays; seg_in is inverted
//                      at the input stage.
module seven_seg_capture #(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   dig_sel,
    input  logic                    clear,
    output logic [4*NUM_DIGITS-1:0] hex_out,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    update,
    output logic                    err
);

    typedef enum logic [1:0] {IDLE, COUNT, HELD} state_t;

    // Count value on the sample just before the capturing one.
    localparam logic [7:0] STABLE_M1 = 8'(STABLE_CYCLES - 1);

    state_t                  state_q, state_d;
    logic [7:0]              cnt_q, cnt_d;
    logic [6:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   sel_q, sel_d;
    logic [6:0]              prev_seg_q, prev_seg_d;
    logic [NUM_DIGITS-1:0]   prev_sel_q, prev_sel_d;
    logic [4*NUM_DIGITS-1:0] hex_q, hex_d;
    logic [NUM_DIGITS-1:0]   valid_q, valid_d;
    logic                    update_q, update_d;
    logic                    err_q, err_d;

    logic                    onehot;
    logic                    same;
    logic                    capture;
    logic [4:0]              dec;

    // Returns {hit, nibble}; hit=0 for anything outside the hex table.
    function automatic logic [4:0] decode_seg(input logic [6:0] s);
        case (s)
            7'h3F:   return {1'b1, 4'h0};
            7'h06:   return {1'b1, 4'h1};
            7'h5B:   return {1'b1, 4'h2};
            7'h4F:   return {1'b1, 4'h3};
            7'h66:   return {1'b1, 4'h4};
            7'h6D:   return {1'b1, 4'h5};
            7'h7D:   return {1'b1, 4'h6};
            7'h07:   return {1'b1, 4'h7};
            7'h7F:   return {1'b1, 4'h8};
            7'h6F:   return {1'b1, 4'h9};
            7'h77:   return {1'b1, 4'hA};
            7'h7C:   return {1'b1, 4'hB};
            7'h39:   return {1'b1, 4'hC};
            7'h5E:   return {1'b1, 4'hD};
            7'h79:   return {1'b1, 4'hE};
            7'h71:   return {1'b1, 4'hF};
            default: return 5'b0;
        endcase
    endfunction

    always_comb begin
`ifdef SEG_ACTIVE_LOW_EN
        seg_d = ~seg_in;
`else
        seg_d = seg_in;
`endif
        sel_d      = dig_sel;
        prev_seg_d = seg_q;
        prev_sel_d = sel_q;
        state_d    = state_q;
        cnt_d      = cnt_q;
        hex_d      = hex_q;
        valid_d    = valid_q;
        err_d      = err_q;
        update_d   = 1'b0;
        capture    = 1'b0;

        onehot = ($countones(sel_q) == 1);
        same   = (seg_q == prev_seg_q) && (sel_q == prev_sel_q);

        if (!onehot) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (state_q == IDLE || !same) begin
            cnt_d = 8'd1;
            if (STABLE_CYCLES == 1) begin
                capture = 1'b1;
                state_d = HELD;
            end else begin
                state_d = COUNT;
            end
        end else if (state_q == COUNT) begin
            cnt_d = cnt_q + 8'd1;
            if (cnt_q == STABLE_M1) begin
                capture = 1'b1;
                state_d = HELD;
            end
        end

        dec = decode_seg(seg_q);
        if (capture) begin
            update_d = 1'b1;
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                if (sel_q[i]) begin
                    if (dec[4]) begin
                        hex_d[4*i +: 4] = dec[3:0];
                        valid_d[i]      = 1'b1;
                    end else begin
                        // Blank and dash are legal "no digit" patterns.
                        valid_d[i] = 1'b0;
                        if (seg_q != 7'h00 && seg_q != 7'h40) begin
                            err_d = 1'b1;
                        end
                    end
                end
            end
        end

        if (clear) begin
            hex_d    = '0;
            valid_d  = '0;
            err_d    = 1'b0;
            update_d = 1'b0;
            state_d  = IDLE;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            seg_q      <= '0;
            sel_q      <= '0;
            prev_seg_q <= '0;
            prev_sel_q <= '0;
            hex_q      <= '0;
            valid_q    <= '0;
            update_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            seg_q      <= seg_d;
            sel_q      <= sel_d;
            prev_seg_q <= prev_seg_d;
            prev_sel_q <= prev_sel_d;
            hex_q      <= hex_d;
            valid_q    <= valid_d;
            update_q   <= update_d;
            err_q      <= err_d;
        end
    end

    assign hex_out     = hex_q;
    assign digit_valid = valid_q;
    assign update      = update_q;
    assign err         = err_q;

endmodule
